pipelined_adder_arbiter: RTL and testbench
==========================================

// Module: pipelined_adder_arbiter
// PURPOSE
//   Shares one fully_pipelined_adder between NREQ requesters.
//   - Round-robin arbitration; at most one operation issued per cycle.
//   - Tracks in-flight operations with a tag pipeline matched to the adder latency.
//   - Routes each {sum, carry} result back to the requester that issued it.
//   - Sits between the requesters and the adder; drives the adder's a, b, c and en inputs.
// PARAMETERS
//   WIDTH    3      operand/sum width; equals the adder WIDTH parameter
//   NREQ     4      number of requesters, 2..8
//   LATENCY  WIDTH  adder issue-to-result latency in enabled cycles; must match the adder
// PORTS
//   clk        in   1           system clock, rising edge
//   rst        in   1           asynchronous active-low reset
//   req_valid  in   NREQ        request pending, per requester
//   req_ready  out  NREQ        one-hot grant; transfer when valid & ready
//   req_a      in   NREQ*WIDTH  operand a; requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand b; same packing as req_a
//   req_c      in   NREQ        carry-in, per requester
//   rsp_valid  out  NREQ        one-hot; result present for requester i
//   rsp_ready  in   NREQ        result accepted (used only with ADDER_ARB_BACKPRESSURE_EN)
//   rsp_s      out  WIDTH       result sum (shared bus)
//   rsp_carry  out  1           result carry-out
//   add_a      out  WIDTH       to adder input a
//   add_b      out  WIDTH       to adder input b
//   add_c      out  1           to adder input c
//   add_en     out  1           to adder en
//   add_s      in   WIDTH       from adder output s
//   add_carry  in   1           from adder output carry
//   busy       out  1           high while any operation is in flight
// BEHAVIOUR
//   Reset (rst=0, async): all outputs 0 except add_en=1; rr pointer=0; tag pipe and in-flight count cleared.
//   Arbitration (combinational, in cycles with add_en=1):
//     - Search starts at the rr pointer and wraps modulo NREQ; the first valid requester wins.
//     - req_ready[winner]=1, all other bits 0. No grant while add_en=0.
//     - req_ready may depend on req_valid; requesters hold valid and operands until granted.
//     - Pointer becomes winner+1 (mod NREQ) only on a grant; it does not move on idle cycles.
//   Issue:
//     - Granted operands are registered onto add_a/b/c at the grant edge.
//     - With no grant, add_a/b/c are held and a bubble tag is issued.
//   Tag pipe: LATENCY+1 stages of {valid, id[$clog2(NREQ)-1:0]}; shifts only when add_en=1.
//   Result:
//     - When the tail tag is valid, rsp_valid[id]=1, rsp_s=add_s, rsp_carry=add_carry.
//     - Bubble tail: rsp_valid=0 and rsp_s/rsp_carry are don't-care.
//   Arithmetic: {rsp_carry, rsp_s} = a + b + c, (WIDTH+1)-bit, with no truncation of the carry.
//   Throughput: one result per cycle. Latency from grant edge to rsp_valid is LATENCY+1 cycles.
//   In-flight count:
//     - Increments on a grant and decrements on result retirement; simultaneous events leave it unchanged.
//     - busy = (count != 0).
//   Single requester: a continuous valid is granted every cycle (back-to-back).
//   Reset mid-operation: in-flight operations are discarded; no rsp_valid is produced for them.
// CONFIGURATION
//   ADDER_ARB_BACKPRESSURE_EN defined:
//     - add_en = ~(tail valid & ~rsp_ready[tail id]).
//     - This freezes the adder, the tag pipe and arbitration; the result is held stable until accepted.
//   ADDER_ARB_BACKPRESSURE_EN undefined:
//     - add_en is tied to 1 and rsp_ready is ignored.
//     - rsp_valid is a single-cycle pulse that the requester must capture.
// TESTING
//   1 Reset: hold rst=0 with random inputs -> req_ready=0, rsp_valid=0, busy=0, add_en=1.
//   2 Single op, WIDTH=3: req0 a=4 b=2 c=1 -> rsp_valid=0001 exactly LATENCY+1 cycles after grant; s=7, carry=0.
//   3 Overflow and ordering: ops 4+3+1 then 7+7+1 back-to-back from req1
//       -> s=0, carry=1, then s=7, carry=1, in issue order.
//   4 Fairness: all NREQ=4 valid continuously -> grants 0,1,2,3,0,... with no requester granted twice in a row.
//   5 Backpressure (macro on): rsp_ready=0 for 3 cycles at result -> rsp held stable, add_en=0, no grants;
//       releases on rsp_ready=1. Macro off: same stimulus -> 1-cycle pulse, add_en stays 1.
//   6 Reset mid-flight: issue 3 ops, assert rst 1 cycle later -> no rsp_valid afterwards, busy=0.

Source files
------------

// File: rtl/pipelined_adder_arbiter.sv
// rtl/pipelined_adder_arbiter.sv - round-robin arbiter sharing one pipelined adder among NREQ requesters
// Optional result backpressure: define ADDER_ARB_BACKPRESSURE_EN.
module pipelined_adder_arbiter #(
   parameter int WIDTH   = 3,
   parameter int NREQ    = 4,
   parameter int LATENCY = WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_c,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_s,
   output logic                  rsp_carry,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   output logic                  add_c,
   output logic                  add_en,
   input  logic [WIDTH-1:0]      add_s,
   input  logic                  add_carry,
   output logic                  busy
);
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNTW = $clog2(LATENCY + 2) + 1;

   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  winner;
   logic            found;
   logic            grant;
   logic [LATENCY:0] tag_v;
   logic [IDW-1:0]  tag_id [LATENCY+1];
   logic            tail_v;
   logic [IDW-1:0]  tail_id;
   logic            retire;
   logic [CNTW-1:0] inflight;

   assign tail_v  = tag_v[LATENCY];
   assign tail_id = tag_id[LATENCY];

`ifdef ADDER_ARB_BACKPRESSURE_EN
   // An unaccepted result freezes the adder, the tag pipe and arbitration together.
   assign add_en = ~(tail_v & ~rsp_ready[tail_id]);
`else
   logic unused_rsp_ready;
   assign unused_rsp_ready = ^rsp_ready;
   assign add_en = 1'b1;
`endif

   // Rotating search starting at rr_ptr; first valid requester wins.
   always_comb begin : arb
      logic [IDW:0] idx;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NREQ)) begin
            idx = idx - (IDW+1)'(NREQ);
         end
         if (!found && req_valid[idx[IDW-1:0]]) begin
            found  = 1'b1;
            winner = idx[IDW-1:0];
         end
      end
   end

   assign grant  = found & add_en & rst;
   assign retire = tail_v & add_en;
   assign busy   = (inflight != '0);

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = grant && (winner == IDW'(i));
         rsp_valid[i] = tail_v && (tail_id == IDW'(i));
      end
   end

   assign rsp_s     = tail_v ? add_s : '0;
   assign rsp_carry = tail_v & add_carry;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr   <= '0;
         add_a    <= '0;
         add_b    <= '0;
         add_c    <= 1'b0;
         tag_v    <= '0;
         inflight <= '0;
         for (int s = 0; s <= LATENCY; s++) begin
            tag_id[s] <= '0;
         end
      end else begin
         if (grant) begin
            rr_ptr <= (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
            add_a  <= req_a[winner*WIDTH +: WIDTH];
            add_b  <= req_b[winner*WIDTH +: WIDTH];
            add_c  <= req_c[winner];
         end
         // Bubbles enter the pipe as invalid tags so the tail stays aligned with the adder output.
         if (add_en) begin
            tag_v     <= {tag_v[LATENCY-1:0], grant};
            tag_id[0] <= winner;
            for (int s = 1; s <= LATENCY; s++) begin
               tag_id[s] <= tag_id[s-1];
            end
         end
         if (grant && !retire) begin
            inflight <= inflight + CNTW'(1);
         end else if (retire && !grant) begin
            inflight <= inflight - CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder_arbiter.sv
// tb/tb_pipelined_adder_arbiter.sv - self-checking bench for pipelined_adder_arbiter
// Honours ADDER_ARB_BACKPRESSURE_EN when the build defines it.
module tb_pipelined_adder_arbiter;
   localparam int WIDTH   = 3;
   localparam int NREQ    = 4;
   localparam int LATENCY = WIDTH;
   localparam int W1      = WIDTH + 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_c;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]      rsp_s;
   logic                  rsp_carry;
   logic [WIDTH-1:0]      add_a;
   logic [WIDTH-1:0]      add_b;
   logic                  add_c;
   logic                  add_en;
   logic [WIDTH-1:0]      add_s;
   logic                  add_carry;
   logic                  busy;

   always #5 clk = ~clk;

   pipelined_adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_s(rsp_s), .rsp_carry(rsp_carry),
      .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_en(add_en),
      .add_s(add_s), .add_carry(add_carry), .busy(busy)
   );

   // External adder: LATENCY enabled stages from sampled inputs to output.
   logic [W1-1:0] apipe [LATENCY];
   always @(posedge clk) begin
      if (add_en) begin
         apipe[0] <= W1'(add_a) + W1'(add_b) + W1'(add_c);
         for (int i = 1; i < LATENCY; i++) apipe[i] <= apipe[i-1];
      end
   end
   assign {add_carry, add_s} = apipe[LATENCY-1];

   typedef struct { int id; int sum; longint due; } op_t;
   typedef struct { int id; int a; int b; int c; int s; int carry; } vec_t;

   op_t    exp_q[$];
   int     rr_ptr;
   longint en_cnt;
   int     n_chk;
   int     n_fail;
   int     m_grant;
   int     m_sum;
   bit     m_present;
   bit     m_en;
   bit     m_in_reset;

   logic [NREQ-1:0]  s_ready;
   logic [NREQ-1:0]  s_rsp_valid;
   logic [WIDTH-1:0] s_rsp_s;
   logic             s_carry;
   logic             s_en;
   logic             s_busy;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int opnd(input logic [NREQ*WIDTH-1:0] v, input int i);
      return int'(v[i*WIDTH +: WIDTH]);
   endfunction

   task automatic model_check();
      int er;
      int ev;
      s_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_s = rsp_s;
      s_carry = rsp_carry; s_en = add_en; s_busy = busy;
      m_grant = -1; m_present = 0; m_en = 1;
      m_in_reset = !rst;
      if (!rst) begin
         chk("rst_req_ready", int'(req_ready), 0);
         chk("rst_rsp_valid", int'(rsp_valid), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_add_en", int'(add_en), 1);
         chk("rst_add_abc", int'({add_a, add_b, add_c}), 0);
         chk("rst_rsp_sum", int'({rsp_carry, rsp_s}), 0);
         return;
      end
      m_present = (exp_q.size() > 0) && (exp_q[0].due == en_cnt);
      ev = m_present ? (1 << exp_q[0].id) : 0;
`ifdef ADDER_ARB_BACKPRESSURE_EN
      m_en = !(m_present && !rsp_ready[exp_q[0].id]);
`endif
      if (m_en) begin
         for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (rr_ptr + k) % NREQ;
            if (m_grant < 0 && req_valid[j]) m_grant = j;
         end
      end
      er = (m_grant >= 0) ? (1 << m_grant) : 0;
      if (m_grant >= 0) m_sum = opnd(req_a, m_grant) + opnd(req_b, m_grant) + int'(req_c[m_grant]);
      chk("req_ready", int'(req_ready), er);
      chk("rsp_valid", int'(rsp_valid), ev);
      chk("add_en", int'(add_en), int'(m_en));
      chk("busy", int'(busy), int'(exp_q.size() != 0));
      if (m_present) chk("rsp_sum", int'({rsp_carry, rsp_s}), exp_q[0].sum);
   endtask

   task automatic model_edge();
      op_t o;
      if (m_in_reset) begin
         exp_q.delete();
         rr_ptr = 0;
         return;
      end
      if (m_en) begin
         if (m_present) void'(exp_q.pop_front());
         if (m_grant >= 0) begin
            o.id = m_grant; o.sum = m_sum; o.due = en_cnt + LATENCY + 1;
            exp_q.push_back(o);
            rr_ptr = (m_grant + 1) % NREQ;
         end
         en_cnt++;
      end
   endtask

   task automatic tick();
      #1;
      model_check();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (s_rsp_valid == '0 && n < LATENCY + 4);
   endtask

   task automatic set_op(input int id, input int a, input int b, input int c);
      req_a[id*WIDTH +: WIDTH] = WIDTH'(a);
      req_b[id*WIDTH +: WIDTH] = WIDTH'(b);
      req_c[id] = c[0];
   endtask

   task automatic rand_drive(input int ready_pct);
      for (int i = 0; i < NREQ; i++) begin
         if (!req_valid[i] || m_grant == i) begin
            req_valid[i] = ($urandom_range(0, 1) == 1);
            set_op(i, int'($urandom_range(0, (1 << WIDTH) - 1)),
                   int'($urandom_range(0, (1 << WIDTH) - 1)), int'($urandom_range(0, 1)));
         end
         rsp_ready[i] = ($urandom_range(0, 99) < ready_pct);
      end
   endtask

   vec_t vt[6];
   int   n;
   int   nb;

   initial begin
      n_chk = 0; n_fail = 0; rr_ptr = 0; en_cnt = 0; m_grant = -1;
      vt[0] = '{0, 4, 2, 1, 7, 0};
      vt[1] = '{1, 4, 3, 1, 0, 1};
      vt[2] = '{1, 7, 7, 1, 7, 1};
      vt[3] = '{2, 0, 0, 0, 0, 0};
      vt[4] = '{3, 5, 6, 0, 3, 1};
      vt[5] = '{2, 7, 0, 1, 0, 1};

      // Reset held with random inputs.
      rst = 1'b0;
      repeat (4) begin
         req_valid = NREQ'($urandom);
         req_a = (NREQ*WIDTH)'($urandom);
         req_b = (NREQ*WIDTH)'($urandom);
         req_c = NREQ'($urandom);
         rsp_ready = NREQ'($urandom);
         tick();
      end
      req_valid = '0; rsp_ready = '1;
      rst = 1'b1;
      repeat (2) tick();

      // Single operations from the vector table.
      for (int v = 0; v < 6; v++) begin
         req_valid = '0;
         req_valid[vt[v].id] = 1'b1;
         set_op(vt[v].id, vt[v].a, vt[v].b, vt[v].c);
         tick();
         chk("vec_grant", int'(s_ready), 1 << vt[v].id);
         req_valid = '0;
         wait_rsp(n);
         chk("vec_latency", n, LATENCY + 1);
         chk("vec_rsp_valid", int'(s_rsp_valid), 1 << vt[v].id);
         chk("vec_s", int'(s_rsp_s), vt[v].s);
         chk("vec_carry", int'(s_carry), vt[v].carry);
      end

      // Back-to-back from one requester: overflow then ordering.
      req_valid = 4'b0010;
      set_op(1, 4, 3, 1);
      tick();
      chk("b2b_grant1", int'(s_ready), 2);
      set_op(1, 7, 7, 1);
      tick();
      chk("b2b_grant2", int'(s_ready), 2);
      req_valid = '0;
      wait_rsp(n);
      chk("b2b_lat", n, LATENCY);
      chk("b2b_first", int'({s_carry, s_rsp_s}), 8);
      tick();
      chk("b2b_second_valid", int'(s_rsp_valid), 2);
      chk("b2b_second", int'({s_carry, s_rsp_s}), 15);
      repeat (LATENCY + 2) tick();

      // Fairness with all requesters continuously valid, starting from pointer 0.
      rst = 1'b0; tick(); rst = 1'b1; tick();
      req_valid = '1;
      nb = 0;
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < NREQ; i++) set_op(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
         tick();
         chk("fair_order", int'(s_ready), 1 << (k % NREQ));
         chk("fair_repeat", int'(s_ready) & nb, 0);
         nb = int'(s_ready);
      end
      req_valid = '0;
      repeat (LATENCY + 3) tick();
      chk("fair_drained_busy", int'(s_busy), 0);

      // Result held off by rsp_ready.
      req_valid = 4'b0001; set_op(0, 1, 1, 0); rsp_ready = '1;
      tick();
      chk("bp_grant", int'(s_ready), 1);
      req_valid = '0; rsp_ready = '0;
      repeat (LATENCY) tick();
      req_valid = 4'b0010; set_op(1, 2, 2, 0);
`ifdef ADDER_ARB_BACKPRESSURE_EN
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_hold_valid", int'(s_rsp_valid), 1);
         chk("bp_hold_sum", int'({s_carry, s_rsp_s}), 2);
         chk("bp_hold_add_en", int'(s_en), 0);
         chk("bp_hold_no_grant", int'(s_ready), 0);
      end
      rsp_ready = '1;
      tick();
      chk("bp_release_valid", int'(s_rsp_valid), 1);
      chk("bp_release_add_en", int'(s_en), 1);
      chk("bp_release_grant", int'(s_ready), 2);
      req_valid = '0;
`else
      tick();
      chk("pulse_valid", int'(s_rsp_valid), 1);
      chk("pulse_sum", int'({s_carry, s_rsp_s}), 2);
      chk("pulse_add_en", int'(s_en), 1);
      chk("pulse_grant", int'(s_ready), 2);
      req_valid = '0;
      tick();
      chk("pulse_gone", int'(s_rsp_valid), 0);
      chk("pulse_add_en2", int'(s_en), 1);
`endif
      rsp_ready = '1;
      repeat (LATENCY + 3) tick();

      // Reset while three operations are in flight.
      req_valid = 4'b0111;
      for (int i = 0; i < 3; i++) set_op(i, 3, 4, 1);
      repeat (3) begin
         tick();
         req_valid = req_valid & ~s_ready;
      end
      req_valid = '0;
      tick();
      chk("mid_busy_before", int'(s_busy), 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int k = 0; k < LATENCY + 3; k++) begin
         tick();
         chk("mid_no_rsp", int'(s_rsp_valid), 0);
         chk("mid_busy", int'(s_busy), 0);
      end

      // Randomised traffic against the reference model.
      repeat (400) begin
         rand_drive(70);
         tick();
      end
      req_valid = '0; rsp_ready = '1;
      repeat (LATENCY + 6) tick();
      chk("final_busy", int'(s_busy), 0);
      chk("final_queue", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
